// File: rtl/control_unit_m.sv
// control_unit_m
//   Decode-stage control unit for the pipelined RV32I core with RV32M
//   sequencing. The RV32I control word is decoded combinationally from the
//   instruction fields. An M-extension op (mul/div/rem) goes through a small
//   IDLE -> BUSY -> DONE sequencer. In IDLE it pulses MDUStartD. It holds
//   StallD high while the fixed-latency MDU works. In DONE it writes the MDU
//   result back through ResultSrcD = 2'b11.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   opcode/funct3/funct7: instruction fields [6:0], [14:12], [31:25]
//   ValidD              : Decode holds a real instruction (0 = bubble)
//   FlushD              : Decode is flushed this cycle (branch/jump resolve)
//   RegWriteD .. ALUControlD : RV32I control word
//   MDUStartD           : one-cycle start pulse to the MDU
//   MDUOpD              : MDU operation (= funct3)
//   StallD              : hold Fetch/Decode, bubble into Execute
//   IllegalInstrD       : instruction cannot be decoded
//   state_dbg           : sequencer state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: ValidD qualifies the instruction fields. StallD is the "not
// ready" back-pressure: while it is high, the instruction in Decode is held
// and must not change. An M instruction is consumed at the clk edge that
// ends its DONE cycle.
module control_unit_m #(
  parameter int ENABLE_M = 1,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       ValidD,
  input  logic       FlushD,
  output logic       RegWriteD,
  output logic [1:0] ResultSrcD,
  output logic       MemWriteD,
  output logic       ALUsrcD,
  output logic [2:0] ImmSrcD,
  output logic       BranchD,
  output logic       JumpD,
  output logic [2:0] R_size,
  output logic [2:0] DMem_size,
  output logic [3:0] ALUControlD,
  output logic       MDUStartD,
  output logic [2:0] MDUOpD,
  output logic       StallD,
  output logic       IllegalInstrD,
  output logic [1:0] state_dbg
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  // All-zero word is the pipeline's canonical bubble/NOP: no effects.
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // BUSY runs while cnt counts LAT-1 down to 0, i.e. exactly LAT cycles.
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic       is_m, m_ok;
  logic       d_regw, d_memw, d_alusrc, d_branch, d_jump, d_illegal;
  logic [1:0] d_rsrc;
  logic [2:0] d_imm, d_rsize, d_dsize;
  logic [3:0] d_alu;
  logic       done_wr;

  // funct7[5] selects sub (register form only) and sra.
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt,
                                         input logic is_reg);
    case (f3)
      3'b000:  alu_dec = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  endfunction

  assign is_m = (opcode == OP_R) && (funct7 == F7_M);
  assign m_ok = is_m && (ENABLE_M != 0);

  // RV32I decode. Illegal encodings leave every enable at its default 0.
  // An M op decodes with RegWrite 0; its write-back is issued from DONE.
  always_comb begin
    d_regw    = 1'b0;
    d_rsrc    = 2'b00;
    d_memw    = 1'b0;
    d_alusrc  = 1'b0;
    d_imm     = 3'b000;
    d_branch  = 1'b0;
    d_jump    = 1'b0;
    d_rsize   = 3'b000;
    d_dsize   = 3'b000;
    d_alu     = ALU_ADD;
    d_illegal = 1'b0;
    if (ValidD) begin
      case (opcode)
        OP_R: begin
          if (funct7 == F7_BASE || funct7 == F7_ALT) begin
            d_regw = 1'b1;
            d_alu  = alu_dec(funct3, funct7[5], 1'b1);
          end else if (!m_ok) begin
            d_illegal = 1'b1;
          end
        end
        OP_I: begin
          d_regw   = 1'b1;
          d_alusrc = 1'b1;
          d_alu    = alu_dec(funct3, funct7[5], 1'b0);
        end
        OP_LOAD: begin
          d_regw   = 1'b1;
          d_rsrc   = 2'b01;
          d_alusrc = 1'b1;
          d_rsize  = funct3;
        end
        OP_STORE: begin
          d_memw   = 1'b1;
          d_alusrc = 1'b1;
          d_imm    = 3'b001;
          d_dsize  = funct3;
        end
        OP_BRANCH: begin
          d_branch = 1'b1;
          d_imm    = 3'b010;
          d_alu    = ALU_SUB;
        end
        OP_JAL: begin
          d_regw = 1'b1;
          d_rsrc = 2'b10;
          d_jump = 1'b1;
          d_imm  = 3'b011;
        end
        OP_JALR: begin
          d_regw   = 1'b1;
          d_rsrc   = 2'b10;
          d_jump   = 1'b1;
          d_alusrc = 1'b1;
        end
        OP_LUI: begin
          d_regw   = 1'b1;
          d_alusrc = 1'b1;
          d_imm    = 3'b100;
          d_alu    = ALU_PASSB;
        end
        OP_AUIPC: begin
          d_regw   = 1'b1;
          d_alusrc = 1'b1;
          d_imm    = 3'b100;
        end
        OP_NOP: begin
        end
        default: d_illegal = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    MDUStartD = 1'b0;
    StallD    = 1'b0;
    done_wr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (ValidD && m_ok && !FlushD) begin
          MDUStartD = 1'b1;
          StallD    = 1'b1;
          cnt_n     = funct3[2] ? DIV_CNT : MUL_CNT;
          state_n   = S_BUSY;
        end
      end
      S_BUSY: begin
        StallD = 1'b1;
        if (cnt != '0) cnt_n = cnt - CNT_ONE;
        else           state_n = S_DONE;
      end
      S_DONE: begin
        // A flushed instruction must not write back its MDU result.
        done_wr = !FlushD;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (FlushD) begin
      state_n   = S_IDLE;
      cnt_n     = '0;
      MDUStartD = 1'b0;
      StallD    = 1'b0;
    end
  end

  assign RegWriteD     = done_wr ? 1'b1 : d_regw;
  assign ResultSrcD    = done_wr ? 2'b11 : d_rsrc;
  assign MemWriteD     = d_memw;
  assign ALUsrcD       = d_alusrc;
  assign ImmSrcD       = d_imm;
  assign BranchD       = d_branch;
  assign JumpD         = d_jump;
  assign R_size        = d_rsize;
  assign DMem_size     = d_dsize;
  assign ALUControlD   = d_alu;
  assign IllegalInstrD = d_illegal;
  assign MDUOpD        = funct3;
  assign state_dbg     = state;

endmodule

// File: tb/tb_control_unit_m.sv
module tb_control_unit_m;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 8;

  localparam logic [31:0] I_ADD = 32'h00B50533;
  localparam logic [31:0] I_MUL = 32'h02B50533;
  localparam logic [31:0] I_DIV = 32'h02B54533;
  localparam logic [31:0] I_BAD = 32'h0000007F;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       ValidD, FlushD, valid_nm, flush_nm;

  logic       RegWriteD, MemWriteD, ALUsrcD, BranchD, JumpD;
  logic       MDUStartD, StallD, IllegalInstrD;
  logic [1:0] ResultSrcD, state_dbg;
  logic [2:0] ImmSrcD, R_size, DMem_size, MDUOpD;
  logic [3:0] ALUControlD;

  logic       nm_regw, nm_memw, nm_alusrc, nm_branch, nm_jump;
  logic       nm_start, nm_stall, nm_illegal;
  logic [1:0] nm_rsrc, nm_state;
  logic [2:0] nm_imm, nm_rsize, nm_dsize, nm_op;
  logic [3:0] nm_alu;

  control_unit_m #(.ENABLE_M(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .ValidD(ValidD), .FlushD(FlushD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .ALUsrcD(ALUsrcD), .ImmSrcD(ImmSrcD), .BranchD(BranchD), .JumpD(JumpD),
    .R_size(R_size), .DMem_size(DMem_size), .ALUControlD(ALUControlD),
    .MDUStartD(MDUStartD), .MDUOpD(MDUOpD), .StallD(StallD),
    .IllegalInstrD(IllegalInstrD), .state_dbg(state_dbg)
  );

  control_unit_m #(.ENABLE_M(0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut_nm (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .ValidD(valid_nm), .FlushD(flush_nm),
    .RegWriteD(nm_regw), .ResultSrcD(nm_rsrc), .MemWriteD(nm_memw),
    .ALUsrcD(nm_alusrc), .ImmSrcD(nm_imm), .BranchD(nm_branch), .JumpD(nm_jump),
    .R_size(nm_rsize), .DMem_size(nm_dsize), .ALUControlD(nm_alu),
    .MDUStartD(nm_start), .MDUOpD(nm_op), .StallD(nm_stall),
    .IllegalInstrD(nm_illegal), .state_dbg(nm_state)
  );

  // ---------------- scoreboard ----------------
  // Vector: {state, stall, start, regw, rsrc[1:0], memw, alusrc, branch, jump, illegal, op[2:0]}
  logic [14:0] exp_q[$];
  logic [14:0] got, want;
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  function automatic logic [14:0] exp_v(input logic [1:0] st, input logic stall,
      input logic start, input logic regw, input logic [1:0] rsrc, input logic memw,
      input logic alusrc, input logic br, input logic jp, input logic ill,
      input logic [2:0] op);
    return {st, stall, start, regw, rsrc, memw, alusrc, br, jp, ill, op};
  endfunction

  function automatic logic [14:0] obs_main();
    return {state_dbg, StallD, MDUStartD, RegWriteD, ResultSrcD, MemWriteD,
            ALUsrcD, BranchD, JumpD, IllegalInstrD, MDUOpD};
  endfunction

  function automatic logic [14:0] obs_nm();
    return {nm_state, nm_stall, nm_start, nm_regw, nm_rsrc, nm_memw,
            nm_alusrc, nm_branch, nm_jump, nm_illegal, nm_op};
  endfunction

  // Expected view of cycle k of an M op with latency lat: start cycle in IDLE,
  // lat BUSY cycles, then DONE writing back through ResultSrc 11.
  function automatic logic [14:0] m_exp(input int k, input int lat, input logic [2:0] op);
    if (k == 0)        return exp_v(2'd0, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0, op);
    else if (k <= lat) return exp_v(2'd1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, op);
    else               return exp_v(2'd2, 0, 0, 1, 2'b11, 0, 0, 0, 0, 0, op);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [31:0] instr, input logic v, input logic f, input logic r);
    opcode = instr[6:0];
    funct3 = instr[14:12];
    funct7 = instr[31:25];
    ValidD = v;
    FlushD = f;
    rst    = r;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      drive(32'h0, 1'b0, 1'b0, 1'b1);
      exp_q.push_back(exp_v(2'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000));
      @(negedge clk);
      got = obs_main(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin fails++; $display("FAIL reset cyc=%0d got=%h exp=%h", k, got, want); end
      else passes++;
    end
  endtask

  task automatic test_add();
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      drive(I_ADD, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(exp_v(2'd0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 3'b000));
      @(negedge clk);
      got = obs_main(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin fails++; $display("FAIL add cyc=%0d got=%h exp=%h", k, got, want); end
      else passes++;
    end
  endtask

  task automatic test_mul();
    for (int k = 0; k <= MUL_LAT + 2; k++) begin
      next_cycle();
      if (k <= MUL_LAT + 1) begin
        drive(I_MUL, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(m_exp(k, MUL_LAT, 3'b000));
      end else begin
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(exp_v(2'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000));
      end
      @(negedge clk);
      got = obs_main(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin fails++; $display("FAIL mul cyc=%0d got=%h exp=%h", k, got, want); end
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    // Two divs held back-to-back: the second starts at cycle DIV_LAT+2.
    int seq = DIV_LAT + 2;
    for (int k = 0; k <= 2 * seq; k++) begin
      next_cycle();
      if (k < 2 * seq) begin
        drive(I_DIV, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(m_exp(k % seq, DIV_LAT, 3'b100));
      end else begin
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(exp_v(2'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000));
      end
      @(negedge clk);
      got = obs_main(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin fails++; $display("FAIL div_b2b cyc=%0d got=%h exp=%h", k, got, want); end
      else passes++;
    end
  endtask

  task automatic test_flush();
    // Flush on cycle 4 of a div, then bubbles: no DONE, no write-back.
    // Finally an M op flushed while still in IDLE must not start.
    for (int k = 0; k < 11; k++) begin
      next_cycle();
      if (k < 4) begin
        drive(I_DIV, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(m_exp(k, DIV_LAT, 3'b100));
      end else if (k == 4) begin
        drive(I_DIV, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(exp_v(2'd1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b100));
      end else if (k == 9) begin
        drive(I_DIV, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(exp_v(2'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b100));
      end else begin
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(exp_v(2'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000));
      end
      @(negedge clk);
      got = obs_main(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin fails++; $display("FAIL flush cyc=%0d got=%h exp=%h", k, got, want); end
      else passes++;
    end
  endtask

  task automatic test_rst_busy();
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      if (k < 3) begin
        drive(I_DIV, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(m_exp(k, DIV_LAT, 3'b100));
      end else if (k == 3) begin
        // Reset is synchronous: this cycle still shows BUSY.
        drive(I_DIV, 1'b1, 1'b0, 1'b1);
        exp_q.push_back(exp_v(2'd1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b100));
      end else begin
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(exp_v(2'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000));
      end
      @(negedge clk);
      got = obs_main(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin fails++; $display("FAIL rst_busy cyc=%0d got=%h exp=%h", k, got, want); end
      else passes++;
    end
  endtask

  task automatic test_illegal_opcode();
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      drive(I_BAD, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(exp_v(2'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 3'b000));
      @(negedge clk);
      got = obs_main(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin fails++; $display("FAIL illegal_op cyc=%0d got=%h exp=%h", k, got, want); end
      else passes++;
    end
  endtask

  task automatic test_no_m();
    // Only the ENABLE_M=0 instance sees a valid mul; it must be illegal.
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      drive(I_MUL, 1'b0, 1'b0, 1'b0);
      valid_nm = 1'b1;
      exp_q.push_back(exp_v(2'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 3'b000));
      @(negedge clk);
      got = obs_nm(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin fails++; $display("FAIL no_m cyc=%0d got=%h exp=%h", k, got, want); end
      else passes++;
    end
    next_cycle();
    valid_nm = 1'b0;
  endtask

  task automatic test_base_decode();
    logic [31:0] tbl_instr[9];
    logic [14:0] tbl_exp[9];
    logic [31:0] ins;
    logic        v;
    int          idx;
    tbl_instr[0] = 32'h00B50533; tbl_exp[0] = exp_v(2'd0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 3'b000); // add
    tbl_instr[1] = 32'h40B50533; tbl_exp[1] = exp_v(2'd0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 3'b000); // sub
    tbl_instr[2] = 32'h00150513; tbl_exp[2] = exp_v(2'd0, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0, 3'b000); // addi
    tbl_instr[3] = 32'h00052503; tbl_exp[3] = exp_v(2'd0, 0, 0, 1, 2'b01, 0, 1, 0, 0, 0, 3'b010); // lw
    tbl_instr[4] = 32'h00B52023; tbl_exp[4] = exp_v(2'd0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 3'b010); // sw
    tbl_instr[5] = 32'h00B50463; tbl_exp[5] = exp_v(2'd0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 3'b000); // beq
    tbl_instr[6] = 32'h008000EF; tbl_exp[6] = exp_v(2'd0, 0, 0, 1, 2'b10, 0, 0, 0, 1, 0, 3'b000); // jal
    tbl_instr[7] = 32'h000015B7; tbl_exp[7] = exp_v(2'd0, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0, 3'b001); // lui
    tbl_instr[8] = 32'h08B50533; tbl_exp[8] = exp_v(2'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 3'b000); // bad funct7
    for (int k = 0; k < 14; k++) begin
      idx = (k < 9) ? k : $urandom_range(0, 8);
      v   = (k < 9) ? 1'b1 : 1'($urandom_range(0, 1));
      ins = tbl_instr[idx];
      next_cycle();
      drive(ins, v, 1'b0, 1'b0);
      if (v) exp_q.push_back(tbl_exp[idx]);
      else   exp_q.push_back(exp_v(2'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, ins[14:12]));
      @(negedge clk);
      got = obs_main(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin fails++; $display("FAIL base_decode idx=%0d v=%0d got=%h exp=%h", idx, v, got, want); end
      else passes++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    valid_nm = 1'b0;
    flush_nm = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b1);
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_flush();
    test_rst_busy();
    test_illegal_opcode();
    test_no_m();
    test_base_decode();
    if (exp_q.size() != 0) begin
      checks++; fails++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1);
  end

endmodule
